// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART 8N1 program loader writing instruction memory
//
// Purpose:
//   Receives a length-prefixed program image over a serial line and writes it
//   into instruction memory from address 0, holding the CPU in reset until a
//   complete, valid image has been written.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN):
//   Defined   : a trailing XOR checksum byte follows the data; mismatch -> error.
//   Undefined : the image is accepted as soon as L data bytes are written.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   rx_in      serial input, idle high, asynchronous to clk
//   start      one-cycle pulse, re-arms the loader from DONE or ERR
//   mem_we     one-cycle instruction memory write strobe
//   mem_addr   write address
//   mem_wdata  write data
//   cpu_hold   high keeps the CPU in reset
//   load_done  image loaded and accepted
//   load_err   framing, length or checksum error

module prog_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_in,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   // Count/length width: must hold the value 256 (L=0) as well as 2^ADDR_W.
   localparam int CW    = (ADDR_W > 8) ? ADDR_W + 1 : 9;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} ld_state_t;

   // ---------------------------------------------------------------- sync
   logic r_rx_s1, r_rx_s2, r_rx_d;
   logic w_fall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= rx_in;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   assign w_fall = r_rx_d & ~r_rx_s2;

   // ------------------------------------------------------------ bit FSM
   rx_state_t        r_rx_state, w_rx_state_nxt;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_byte_valid;
   logic             r_frame_err;
   logic             w_tick_half, w_tick_full;

   assign w_tick_half = (r_baud_cnt == CNT_W'(HALF - 1));
   assign w_tick_full = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (w_fall) w_rx_state_nxt = RX_START;
         // Line high at mid start bit is a glitch: drop it silently.
         RX_START: if (w_tick_half) w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick_full && r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
         RX_STOP:  if (w_tick_full) w_rx_state_nxt = RX_IDLE;
         default:  w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_state <= RX_IDLE;
      end else begin
         r_rx_state <= w_rx_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_baud_cnt   <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         // Counter restarts on every state change and after each data sample,
         // so the first data sample lands one full bit after mid start bit.
         if (r_rx_state == RX_IDLE || w_rx_state_nxt != r_rx_state ||
             (r_rx_state == RX_DATA && w_tick_full))
            r_baud_cnt <= '0;
         else
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);

         if (r_rx_state == RX_START)
            r_bit_idx <= '0;
         else if (r_rx_state == RX_DATA && w_tick_full)
            r_bit_idx <= r_bit_idx + 3'd1;

         if (r_rx_state == RX_DATA && w_tick_full)
            r_shift <= {r_rx_s2, r_shift[7:1]};

         r_byte_valid <= (r_rx_state == RX_STOP) && w_tick_full &&  r_rx_s2;
         r_frame_err  <= (r_rx_state == RX_STOP) && w_tick_full && !r_rx_s2;
      end
   end

   // ----------------------------------------------------------- byte FSM
   ld_state_t         r_st, w_st_nxt;
   logic [CW-1:0]     r_len, r_cnt;
   logic [CW-1:0]     w_len;
   logic              w_len_bad, w_last;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;
   logic              r_cpu_hold, r_load_done, r_load_err;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   // L=0 encodes a full 256-byte image.
   assign w_len     = (r_shift == 8'd0) ? CW'(256) : CW'(r_shift);
   assign w_len_bad = (ADDR_W < 8) && (w_len > CW'(2 ** ADDR_W));
   assign w_last    = ((r_cnt + CW'(1)) == r_len);

   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         S_LEN: begin
            if (r_frame_err)       w_st_nxt = S_ERR;
            else if (r_byte_valid) w_st_nxt = w_len_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            if (r_frame_err) w_st_nxt = S_ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
            else if (r_byte_valid && w_last) w_st_nxt = S_CSUM;
`else
            else if (r_byte_valid && w_last) w_st_nxt = S_DONE;
`endif
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (r_frame_err)       w_st_nxt = S_ERR;
            else if (r_byte_valid) w_st_nxt = (r_shift == r_csum) ? S_DONE : S_ERR;
         end
`endif
         // Start takes priority; received bytes are ignored here.
         S_DONE, S_ERR: if (start) w_st_nxt = S_LEN;
         default: w_st_nxt = S_LEN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st <= S_LEN;
      end else begin
         r_st <= w_st_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_len       <= '0;
         r_cnt       <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_hold  <= 1'b1;
         r_load_done <= 1'b0;
         r_load_err  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         r_csum      <= '0;
`endif
      end else begin
         r_mem_we    <= 1'b0;
         // Status follows the next state so it changes with the transition.
         r_cpu_hold  <= (w_st_nxt != S_DONE);
         r_load_done <= (w_st_nxt == S_DONE);
         r_load_err  <= (w_st_nxt == S_ERR);

         if (r_st == S_LEN && r_byte_valid) begin
            r_len <= w_len;
            r_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum <= '0;
`endif
         end

         if (r_st == S_DATA && r_byte_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt[ADDR_W-1:0];
            r_mem_wdata <= r_shift;
            r_cnt       <= r_cnt + CW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum      <= r_csum ^ r_shift;
`endif
         end

         if ((r_st == S_DONE || r_st == S_ERR) && start)
            r_mem_addr <= '0;
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_hold  = r_cpu_hold;
   assign load_done = r_load_done;
   assign load_err  = r_load_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

   localparam int CPB = 16;
   localparam int AW  = 8;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rx_in = 1'b1;
   logic          start = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          cpu_hold, load_done, load_err;

   prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .rx_in(rx_in), .start(start),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: expected writes in order and expected settled status.
   int  exp_addr_q[$];
   int  exp_data_q[$];
   bit  exp_done = 1'b0;
   bit  exp_err  = 1'b0;
   bit  status_valid = 1'b0;
   logic prev_we = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset) begin
         if (mem_we) begin
            n_cmp++;
            if (exp_addr_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
               int a, d;
               a = exp_addr_q.pop_front();
               d = exp_data_q.pop_front();
               if (int'(mem_addr) != a || int'(mem_wdata) != d) begin
                  n_bad++;
                  $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                           mem_addr, mem_wdata, a, d);
               end
            end
            if (prev_we) begin
               n_bad++;
               $display("FAIL we_width: got mem_we high 2 cycles expected 1");
            end
         end
         if (status_valid) begin
            n_cmp++;
            if (load_done !== exp_done || load_err !== exp_err || cpu_hold !== !exp_done) begin
               n_bad++;
               $display("FAIL status: got done %0b err %0b hold %0b expected done %0b err %0b hold %0b",
                        load_done, load_err, cpu_hold, exp_done, exp_err, !exp_done);
            end
         end
      end
      prev_we = mem_we;
   end

   // Behavioural image model: bytes[0] is length, then data, then checksum.
   task automatic model_image(input bq_t b, input int bad_idx);
      int len;
      logic [7:0] x;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      len = (b[0] == 8'd0) ? 256 : int'(b[0]);
      x = 8'h00;
      if (bad_idx == 0) begin exp_err = 1'b1; return; end
      for (int i = 1; i <= len; i++) begin
         if (i == bad_idx) begin exp_err = 1'b1; return; end
         exp_addr_q.push_back(i - 1);
         exp_data_q.push_back(int'(b[i]));
         x = x ^ b[i];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (bad_idx == len + 1) begin exp_err = 1'b1; return; end
      if (b[len+1] == x) exp_done = 1'b1;
      else               exp_err  = 1'b1;
`else
      exp_done = 1'b1;
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx_in = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_in = bad_stop ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
      rx_in = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic run_image(input bq_t b, input int bad_idx, input string tag);
      model_image(b, bad_idx);
      status_valid = 1'b0;
      foreach (b[i]) send_byte(b[i], i == bad_idx);
      repeat (20) @(negedge clk);
      chk({tag, " writes_pending"}, exp_addr_q.size(), 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      chk({tag, " load_done"}, int'(load_done), int'(exp_done));
      chk({tag, " load_err"},  int'(load_err),  int'(exp_err));
      chk({tag, " cpu_hold"},  int'(cpu_hold),  int'(!exp_done));
      status_valid = 1'b1;
   endtask

   task automatic pulse_start(input string tag);
      bit rearm;
      rearm = exp_done || exp_err;
      status_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (rearm) begin exp_done = 1'b0; exp_err = 1'b0; end
      repeat (3) @(negedge clk);
      chk({tag, " start_hold"}, int'(cpu_hold), int'(!exp_done));
      chk({tag, " start_done"}, int'(load_done), int'(exp_done));
      if (rearm) chk({tag, " start_addr"}, int'(mem_addr), 0);
      status_valid = 1'b1;
   endtask

   initial begin
      bq_t img;
      int  len, bad;
      logic [7:0] x;

      // Reset values while held in reset.
      repeat (3) @(negedge clk);
      chk("rst mem_we", int'(mem_we), 0);
      chk("rst mem_addr", int'(mem_addr), 0);
      chk("rst mem_wdata", int'(mem_wdata), 0);
      chk("rst cpu_hold", int'(cpu_hold), 1);
      chk("rst load_done", int'(load_done), 0);
      chk("rst load_err", int'(load_err), 0);
      reset = 1'b1;
      status_valid = 1'b1;
      repeat (1000) @(negedge clk);
      chk("idle cpu_hold", int'(cpu_hold), 1);

      // Pin the model against hand-computed values.
      img = '{8'h03, 8'hA1, 8'h42, 8'h0F, 8'hEC};
      model_image(img, -1);
      chk("model n_writes", exp_addr_q.size(), 3);
      chk("model w0", exp_data_q[0], 'hA1);
      chk("model w2", exp_data_q[2], 'h0F);
      chk("model a2", exp_addr_q[2], 2);
      chk("model done", int'(exp_done), 1);
      exp_addr_q.delete();
      exp_data_q.delete();
      img = '{8'h03, 8'hA1, 8'h42, 8'h0F, 8'hED};
      model_image(img, -1);
`ifdef PROG_LOADER_CHECKSUM_EN
      chk("model badcsum err", int'(exp_err), 1);
`else
      chk("model badcsum done", int'(exp_done), 1);
`endif
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;

      // Good image.
      run_image('{8'h03, 8'hA1, 8'h42, 8'h0F, 8'hEC}, -1, "good");
      chk("good last_addr", int'(mem_addr), 2);
      chk("good last_data", int'(mem_wdata), 'h0F);
      pulse_start("good");

      // Bad checksum.
      run_image('{8'h03, 8'hA1, 8'h42, 8'h0F, 8'hED}, -1, "badcsum");
      pulse_start("badcsum");

      // Framing error on first data byte, then bytes that must be ignored.
      run_image('{8'h02, 8'h55, 8'h33, 8'h44}, 1, "frame");
      chk("frame err_lit", int'(load_err), 1);
      pulse_start("frame");

      // Idle glitch: no byte, no error.
      rx_in = 1'b0;
      repeat (3) @(negedge clk);
      rx_in = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch err", int'(load_err), 0);
      run_image('{8'h01, 8'h7E, 8'h7E}, -1, "glitch_img");
      chk("glitch_img done_lit", int'(load_done), 1);
      pulse_start("restart");
      run_image('{8'h01, 8'h7E, 8'h7E}, -1, "restart_img");

      // Start while loading is ignored.
      pulse_start("restart_done");
      status_valid = 1'b0;
      model_image('{8'h02, 8'h10, 8'h20, 8'h30}, -1);
      send_byte(8'h02, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      repeat (20) @(negedge clk);
      chk("ignstart writes_pending", exp_addr_q.size(), 0);
      chk("ignstart done", int'(load_done), int'(exp_done));
      status_valid = 1'b1;
      pulse_start("ignstart");

      // Randomized images.
      for (int n = 0; n < 10; n++) begin
         img.delete();
         len = $urandom_range(1, 6);
         img.push_back(8'(len));
         x = 8'h00;
         for (int i = 0; i < len; i++) begin
            img.push_back(8'($urandom_range(0, 255)));
            x = x ^ img[i+1];
         end
         if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
         img.push_back(x);
         img.push_back(8'($urandom_range(0, 255)));
         bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 2)) : -1;
         run_image(img, bad, $sformatf("rand%0d", n));
         pulse_start($sformatf("rand%0d", n));
      end

      // Reset in the middle of the second data byte of a 4-byte image.
      status_valid = 1'b0;
      send_byte(8'h04, 1'b0);
      exp_addr_q.push_back(0);
      exp_data_q.push_back('h11);
      send_byte(8'h11, 1'b0);
      rx_in = 1'b0;
      repeat (40) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst mem_we", int'(mem_we), 0);
      chk("midrst mem_addr", int'(mem_addr), 0);
      chk("midrst mem_wdata", int'(mem_wdata), 0);
      chk("midrst cpu_hold", int'(cpu_hold), 1);
      chk("midrst load_done", int'(load_done), 0);
      chk("midrst load_err", int'(load_err), 0);
      chk("midrst writes_pending", exp_addr_q.size(), 0);
      rx_in = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      repeat (20) @(negedge clk);
      run_image('{8'h02, 8'h5A, 8'hA5, 8'hFF}, -1, "postrst");
      chk("postrst last_addr", int'(mem_addr), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
